sized_data_memory: RTL and testbench

SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

---
 rtl/data_memory_pkg.sv | 13 +
 rtl/load_aligner.sv | 35 +++
 rtl/sized_data_memory.sv | 127 ++++++++++++
 tb/tb_sized_data_memory.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared access-size codes and FSM state type for sized_data_memory
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - extracts the addressed byte/half/word and sign- or zero-extends it
module load_aligner
  import data_memory_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (size)
      SIZE_BYTE: result = {{24{~unsignedLoad & byte_sel[7]}}, byte_sel};
      SIZE_HALF: result = {{16{~unsignedLoad & half_sel[15]}}, half_sel};
      default:   result = word;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// rtl/sized_data_memory.sv - byte-addressed data memory with sized loads/stores and clear-after-reset
module sized_data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [1:0]            size,
  input  logic                  unsignedLoad,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  readValid,
  output logic                  error,
  output logic                  ready
);

  localparam int     IDX_W       = $clog2(DEPTH);
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  logic [3:0][7:0] mem [DEPTH];

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;
  logic             clear_we;

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept, fault, out_of_range, store_ok;
  logic [3:0]       byte_en;
  logic [3:0][7:0]  wr_lanes;
  logic [31:0]      load_res;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clear_we    = 1'b0;
    case (state)
      CLEAR: begin
        clear_we = 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state == IDLE);

  assign idx          = address[IDX_W+1:2];
  assign lane         = address[1:0];
  assign accept       = ready & ~reset & (MemRead | MemWrite);
  assign out_of_range = {1'b0, address} >= (ADDR_WIDTH+1)'(4 * DEPTH);
  assign fault        = out_of_range
                      | (size == 2'b11)
                      | ((size == SIZE_HALF) & address[0])
                      | ((size == SIZE_WORD) & (address[1:0] != 2'b00));
  assign store_ok     = accept & MemWrite & ~fault;

  // Replicate the right-aligned store data across lanes; byte_en picks which land.
  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = writeData;
    case (size)
      SIZE_BYTE: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{writeData[7:0]}};
      end
      SIZE_HALF: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{writeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear_we) begin
      mem[clr_cnt] <= '0;
    end else if (store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][i] <= wr_lanes[i];
      end
    end
  end

  load_aligner u_load_aligner (
    .word         (mem[idx]),
    .lane         (lane),
    .size         (size),
    .unsignedLoad (unsignedLoad),
    .result       (load_res)
  );

  // load_res is sampled from the pre-edge array, so a same-cycle store is read-first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readData  <= '0;
      readValid <= 1'b0;
      error     <= 1'b0;
    end else begin
      readValid <= accept & MemRead;
      error     <= accept & fault;
      if (accept & MemRead) readData <= fault ? 32'h0 : load_res;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// tb/tb_sized_data_memory.sv - directed self-checking bench for sized_data_memory
module tb_sized_data_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] address = '0;
  logic [1:0]  size = 2'b10;
  logic        unsignedLoad = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        readValid;
  logic        error;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  sized_data_memory #(.DEPTH(32), .ADDR_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .address      (address),
    .size         (size),
    .unsignedLoad (unsignedLoad),
    .writeData    (writeData),
    .readData     (readData),
    .readValid    (readValid),
    .error        (error),
    .ready        (ready)
  );

  always #5 clock = ~clock;

  task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        output logic [31:0] rd, output logic rv, output logic er);
    @(negedge clock);
    MemWrite = w; MemRead = r; address = a; size = sz; unsignedLoad = u; writeData = wd;
    @(posedge clock);
    #1;
    rd = readData; rv = readValid; er = error;
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic test_reset();
    int edges;
    logic [31:0] rd;
    logic rv, er;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (readData !== 32'h0 || readValid !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%h rv=%b err=%b, expected 0/0/0", readData, readValid, error);
    end
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    @(negedge clock);
    reset = 1'b0;
    edges = 0;
    while (edges < 100) begin
      @(posedge clock); #1;
      edges++;
      if (ready === 1'b1) break;
    end
    n_checks++;
    if (edges != 32) begin n_fail++; $display("FAIL clear_length: got %0d edges expected 32", edges); end
    do_req(1'b0, 1'b1, 32'h7C, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h0 || rv !== 1'b1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_7c_cleared: got rd=%h rv=%b err=%b, expected 00000000/1/0", rd, rv, er);
    end
    do_req(1'b0, 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rv !== 1'b0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL no_request: got rv=%b err=%b, expected 0/0", rv, er);
    end
  endtask

  task automatic test_subword();
    logic [31:0] rd;
    logic rv, er;
    logic [31:0] exp_rd [5]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD, 32'h0000BEEF};
    logic [31:0] addrs  [5]  = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10};
    logic [1:0]  sizes  [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    logic        uns    [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_req(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, rv, er);
    n_checks++;
    if (rv !== 1'b0 || er !== 1'b0) begin
      n_fail++; $display("FAIL sw_10_flags: got rv=%b err=%b, expected 0/0", rv, er);
    end
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, 1'b1, addrs[i], sizes[i], uns[i], 32'h0, rd, rv, er);
      n_checks++;
      if (rd !== exp_rd[i] || rv !== 1'b1 || er !== 1'b0) begin
        n_fail++;
        $display("FAIL subword_load_%0d: got rd=%h rv=%b err=%b, expected %h/1/0", i, rd, rv, er, exp_rd[i]);
      end
    end
    do_req(1'b1, 1'b0, 32'h11, 2'b00, 1'b0, 32'hFFFFFF55, rd, rv, er);
    do_req(1'b0, 1'b1, 32'h10, 2'b10, 1'b1, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_then_lw: got %h expected DEAD55EF", rd); end
    do_req(1'b1, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0000A1B2, rd, rv, er);
    do_req(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'hA1B255EF) begin n_fail++; $display("FAIL sh_then_lw: got %h expected A1B255EF", rd); end
    do_req(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'hA1B255EF || rv !== 1'b0) begin
      n_fail++; $display("FAIL readdata_hold: got rd=%h rv=%b, expected A1B255EF/0", rd, rv);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic rv, er;
    do_req(1'b0, 1'b1, 32'h12, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h0 || rv !== 1'b1 || er !== 1'b1) begin
      n_fail++; $display("FAIL lw_misaligned: got rd=%h rv=%b err=%b, expected 0/1/1", rd, rv, er);
    end
    do_req(1'b1, 1'b0, 32'h80, 2'b10, 1'b0, 32'h1, rd, rv, er);
    n_checks++;
    if (er !== 1'b1 || rv !== 1'b0) begin
      n_fail++; $display("FAIL sw_out_of_range: got err=%b rv=%b, expected 1/0", er, rv);
    end
    do_req(1'b0, 1'b1, 32'h00, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL lw_0_after_oor: got rd=%h err=%b, expected 0/0", rd, er);
    end
    do_req(1'b1, 1'b0, 32'h11, 2'b01, 1'b0, 32'hFFFF, rd, rv, er);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL sh_misaligned: got err=%b expected 1", er); end
    do_req(1'b0, 1'b1, 32'h10, 2'b11, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h0 || rv !== 1'b1 || er !== 1'b1) begin
      n_fail++; $display("FAIL illegal_size: got rd=%h rv=%b err=%b, expected 0/1/1", rd, rv, er);
    end
    do_req(1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'hA1B255EF || er !== 1'b0) begin
      n_fail++; $display("FAIL faults_left_array: got rd=%h err=%b, expected A1B255EF/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic rv, er;
    do_req(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'hCAFEF00D, rd, rv, er);
    do_req(1'b1, 1'b1, 32'h20, 2'b10, 1'b0, 32'h12345678, rd, rv, er);
    n_checks++;
    if (rd !== 32'hCAFEF00D || rv !== 1'b1 || er !== 1'b0) begin
      n_fail++; $display("FAIL read_first: got rd=%h rv=%b err=%b, expected CAFEF00D/1/0", rd, rv, er);
    end
    do_req(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL after_same_cycle: got %h expected 12345678", rd); end
    do_req(1'b1, 1'b0, 32'h7C, 2'b10, 1'b0, 32'hA5A5A5A5, rd, rv, er);
    do_req(1'b0, 1'b1, 32'h7F, 2'b00, 1'b1, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h000000A5 || er !== 1'b0) begin
      n_fail++; $display("FAIL lbu_top_byte: got rd=%h err=%b, expected 000000A5/0", rd, er);
    end
  endtask

  task automatic test_reset_during_clear();
    int edges;
    int bad;
    logic [31:0] rd;
    logic rv, er;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (readData !== 32'h0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got rd=%h ready=%b, expected 0/0", readData, ready);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_midclear: got %b expected 0", ready); end
    @(negedge clock);
    reset = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b1; address = 32'h12; size = 2'b10; writeData = 32'hFFFFFFFF;
    edges = 0;
    bad = 0;
    while (edges < 100) begin
      @(posedge clock); #1;
      edges++;
      if (readValid !== 1'b0 || error !== 1'b0) bad++;
      if (ready === 1'b1) break;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    n_checks++;
    if (edges != 32) begin n_fail++; $display("FAIL restart_clear_length: got %0d edges expected 32", edges); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL requests_in_clear: got %0d pulses expected 0", bad); end
    do_req(1'b0, 1'b1, 32'h7C, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      n_fail++; $display("FAIL lw_7c_recleared: got rd=%h rv=%b, expected 0/1", rd, rv);
    end
    do_req(1'b0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h0, rd, rv, er);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL lw_20_recleared: got %h expected 0", rd); end
  endtask

  initial begin
    test_reset();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_during_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
